// File: rtl/top_linear_inverse_pipe.sv
// AES inverse affine transform on every byte of a NUM_BYTES-wide word, behind a 2-deep
// valid/ready skid stage. Optional transfer counter enabled by TOP_LINEAR_INV_XFER_CNT_EN.
module top_linear_inverse_pipe #(
   parameter int unsigned NUM_BYTES = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [8*NUM_BYTES-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [8*NUM_BYTES-1:0] out_data
`ifdef TOP_LINEAR_INV_XFER_CNT_EN
   ,
   output logic [31:0]            xfer_cnt,
   output logic [0:0]             overflow_flag
`endif
);

   localparam int unsigned W = 8 * NUM_BYTES;

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e         state_q, state_d;
   logic [W-1:0]   oreg_q, oreg_d;
   logic [W-1:0]   sreg_q, sreg_d;
   logic           out_valid_q, out_valid_d;
   logic           in_ready_q, in_ready_d;
   logic [W-1:0]   xf_data;
   logic           in_xfer, out_xfer;

   function automatic logic [7:0] inv_affine(input logic [7:0] x);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) begin
         b[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8];
      end
      return b ^ 8'h05;
   endfunction

   always_comb begin
      xf_data = '0;
      for (int k = 0; k < int'(NUM_BYTES); k++) begin
         xf_data[8*k +: 8] = inv_affine(in_data[8*k +: 8]);
      end
   end

   assign in_xfer  = in_valid && in_ready_q;
   assign out_xfer = out_valid_q && out_ready;

   always_comb begin
      state_d = state_q;
      oreg_d  = oreg_q;
      sreg_d  = sreg_q;
      unique case (state_q)
         StEmpty: begin
            if (in_xfer) begin
               state_d = StOne;
               oreg_d  = xf_data;
            end
         end
         StOne: begin
            if (in_xfer && out_xfer) begin
               oreg_d = xf_data;
            end else if (in_xfer) begin
               state_d = StFull;
               sreg_d  = xf_data;
            end else if (out_xfer) begin
               state_d = StEmpty;
            end
         end
         StFull: begin
            if (out_xfer) begin
               state_d = StOne;
               oreg_d  = sreg_q;
            end
         end
         default: state_d = StEmpty;
      endcase
      // Flags follow the next state so they are pure flop outputs.
      out_valid_d = (state_d != StEmpty);
      in_ready_d  = (state_d != StFull);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StEmpty;
         oreg_q      <= '0;
         sreg_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         oreg_q      <= oreg_d;
         sreg_q      <= sreg_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = oreg_q;

`ifdef TOP_LINEAR_INV_XFER_CNT_EN
   logic [31:0] xfer_cnt_q, xfer_cnt_d;
   logic        overflow_q, overflow_d;

   always_comb begin
      xfer_cnt_d = xfer_cnt_q;
      overflow_d = overflow_q;
      if (out_xfer) begin
         xfer_cnt_d = xfer_cnt_q + 32'd1;
         if (xfer_cnt_q == 32'hFFFF_FFFF) begin
            overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         xfer_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         xfer_cnt_q <= xfer_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   assign xfer_cnt      = xfer_cnt_q;
   assign overflow_flag = overflow_q;
`endif

endmodule

// File: tb/tb_top_linear_inverse_pipe.sv
// Scoreboard bench for top_linear_inverse_pipe: driver pushes expected words, a negedge
// monitor pops and compares on every output transfer.
module tb_top_linear_inverse_pipe;

   localparam int unsigned NB = 4;
   localparam int unsigned W  = 8 * NB;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_data;
`ifdef TOP_LINEAR_INV_XFER_CNT_EN
   logic [31:0]   xfer_cnt;
   logic [0:0]    overflow_flag;
`endif

   logic          fixed_ready = 1'b0;
   logic          rand_ready  = 1'b0;
   logic [W-1:0]  exp_q[$];
   int            errors = 0;
   int            checks = 0;
   logic          hold_valid = 1'b0;
   logic [W-1:0]  hold_data;

   top_linear_inverse_pipe #(.NUM_BYTES(NB)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data)
`ifdef TOP_LINEAR_INV_XFER_CNT_EN
      ,
      .xfer_cnt      (xfer_cnt),
      .overflow_flag (overflow_flag)
`endif
   );

   always #5 clk = ~clk;

   // Sole driver of out_ready; updates 2 time units after each rising edge.
   always @(posedge clk) begin
      #2;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
   end

   function automatic logic [7:0] model8(input logic [7:0] x);
      return {x[1:0], x[7:2]} ^ {x[4:0], x[7:5]} ^ {x[6:0], x[7]} ^ 8'h05;
   endfunction

   function automatic logic [W-1:0] model(input logic [W-1:0] d);
      logic [W-1:0] r;
      for (int k = 0; k < int'(NB); k++) r[8*k +: 8] = model8(d[8*k +: 8]);
      return r;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pop and compare on every output transfer; also checks hold stability.
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %h expected none at %0t", out_data, $time);
            end else begin
               chk("out_data", out_data, exp_q.pop_front());
            end
            hold_valid = 1'b0;
         end else if (out_valid === 1'b1) begin
            if (hold_valid) chk("stable_under_stall", out_data, hold_data);
            hold_valid = 1'b1;
            hold_data  = out_data;
         end else begin
            hold_valid = 1'b0;
         end
      end else begin
         hold_valid = 1'b0;
      end
   end

   task automatic send(input logic [W-1:0] d, input logic [W-1:0] e);
      int  n;
      bit  done;
      n = 0;
      done = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      while (!done && n < 200) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            exp_q.push_back(e);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready=0 expected acceptance of %h", d);
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_data  = 'x;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      chk("drain_queue_empty", W'(exp_q.size()), '0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      #2;
      chk("reset_out_valid", W'(out_valid), '0);
      chk("reset_in_ready", W'(in_ready), '0);
      chk("reset_out_data", out_data, '0);
      #10 reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_reset_in_ready", W'(in_ready), W'(1));
      chk("post_reset_out_valid", W'(out_valid), '0);

      // Directed single-lane vectors (upper lanes zero -> 8'h05 each).
      fixed_ready = 1'b1;
      send(32'h0000_0063, 32'h0505_0500);
      idle();
      @(negedge clk);
      chk("latency_one_cycle", W'(out_valid), W'(1));
      @(posedge clk);
      #1;
      send(32'h0000_007C, 32'h0505_0501);
      send(32'h0000_0016, 32'h0505_051C);
      send(32'h0000_0000, 32'h0505_0505);
      send(32'h167C_6300, 32'h1C01_0005);
      idle();
      wait_drain();

      // Sweep every byte value through every lane, back to back.
      for (int v = 0; v < 256; v++) begin
         logic [W-1:0] w;
         w = {8'(v + 3), 8'(v + 2), 8'(v + 1), 8'(v)};
         send(w, model(w));
      end
      idle();
      wait_drain();

      // Backpressure: fill both registers, confirm third word is refused.
      fixed_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      send(32'hA1A2_A3A4, model(32'hA1A2_A3A4));
      send(32'hB1B2_B3B4, model(32'hB1B2_B3B4));
      in_valid = 1'b1;
      in_data  = 32'hC1C2_C3C4;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("full_in_ready_low", W'(in_ready), '0);
         chk("full_out_valid", W'(out_valid), W'(1));
         chk("full_out_data_a", out_data, model(32'hA1A2_A3A4));
      end
      @(posedge clk);
      #1;
      idle();
      fixed_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("release_in_ready", W'(in_ready), W'(1));
      chk("release_b_next_valid", W'(out_valid), W'(1));
      chk("release_b_next_data", out_data, model(32'hB1B2_B3B4));
      wait_drain();

      // Random stream with random downstream readiness.
      rand_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         logic [W-1:0] w;
         w = W'($urandom());
         send(w, model(w));
      end
      idle();
      rand_ready  = 1'b0;
      fixed_ready = 1'b1;
      wait_drain();

      // Asynchronous reset while FULL.
      fixed_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      send(32'h1111_2222, model(32'h1111_2222));
      send(32'h3333_4444, model(32'h3333_4444));
      idle();
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("midreset_out_valid", W'(out_valid), '0);
      chk("midreset_out_data", out_data, '0);
      chk("midreset_in_ready", W'(in_ready), '0);
      exp_q.delete();
      #2 reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("after_reset_in_ready", W'(in_ready), W'(1));
      fixed_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("no_stale_words", W'(out_valid), '0);

`ifdef TOP_LINEAR_INV_XFER_CNT_EN
      for (int i = 0; i < 5; i++) send(W'(i), model(W'(i)));
      idle();
      wait_drain();
      chk("xfer_cnt_5", xfer_cnt, 32'd5);
      chk("overflow_clear", W'(overflow_flag), '0);
      @(posedge clk);
      #1;
      force dut.xfer_cnt_q = 32'hFFFF_FFFE;
      #1 release dut.xfer_cnt_q;
      send(32'h0, model(32'h0));
      send(32'h1, model(32'h1));
      idle();
      wait_drain();
      chk("xfer_cnt_wrap", xfer_cnt, 32'd0);
      chk("overflow_set", W'(overflow_flag), W'(1));
      send(32'h2, model(32'h2));
      idle();
      wait_drain();
      chk("overflow_sticky", W'(overflow_flag), W'(1));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
